uart_rx_fifo: RTL

- Serial receive front end feeding the memory manager's memory-mapped UART input.
- Takes the raw `uart_txd_in` pin, oversamples it in the CPU clock domain and frames 8N1 characters.
- Buffers received bytes in a small FIFO that the CPU drains by load-triggered pops.
- Raises sticky framing-error and overrun flags.

---
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU-side pop/flag bus of the UART receive FIFO
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic          rx_pop;
    logic          err_clr;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overrun;
    modport master (
        output rx_pop, err_clr,
        input  rx_data, rx_valid, rx_count, frame_err, overrun
    );
    modport slave (
        input  rx_pop, err_clr,
        output rx_data, rx_valid, rx_count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 receiver feeding a small byte FIFO with sticky error flags
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK100MHZ,
    input  logic          rst_n,
    input  logic          uart_txd_in,
    uart_rx_fifo_if.slave bus
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int NW   = $clog2(CPB + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [1:0]    sync_q;
    logic [NW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          armed_q, done_q, ok_q, s;
    assign s = sync_q[1];
    // armed_q blocks re-triggering until the line has been seen idle (after reset or a break)
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], uart_txd_in};
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (!armed_q) armed_q <= s;
                    else if (!s) state_q <= START;
                end
                START: if (baud_q == NW'(HALF - 1)) begin
                    baud_q  <= '0;
                    bit_q   <= '0;
                    state_q <= s ? IDLE : DATA;
                end else baud_q <= baud_q + 1'b1;
                DATA: if (baud_q == NW'(CPB - 1)) begin
                    baud_q  <= '0;
                    shift_q <= {s, shift_q[7:1]};
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == 3'd7) state_q <= STOP;
                end else baud_q <= baud_q + 1'b1;
                STOP: if (baud_q == NW'(CPB - 1)) begin
                    baud_q  <= '0;
                    done_q  <= 1'b1;
                    ok_q    <= s;
                    armed_q <= s;
                    state_q <= IDLE;
                end else baud_q <= baud_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fe_q, fe_d, ov_q, ov_d, full, push, pop;
    always_comb begin
        full  = cnt_q == CW'(FIFO_DEPTH);
        pop   = bus.rx_pop && cnt_q != '0;
        push  = done_q && ok_q && (!full || pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        fe_d  = (done_q && !ok_q) || (fe_q && !bus.err_clr);
        ov_d  = (done_q && ok_q && full && !pop) || (ov_q && !bus.err_clr);
    end
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            fe_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= shift_q;
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_d;
            fe_q  <= fe_d;
            ov_q  <= ov_d;
        end
    end
    assign bus.rx_data   = mem_q[rd_q];
    assign bus.rx_valid  = cnt_q != '0;
    assign bus.rx_count  = cnt_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;
endmodule
